// File: rtl/branch_target_buffer_pkg.sv
// Shared types and helpers for the fetch-stage branch target buffer.
// Tags are carried zero-extended to TAG_MAX so the entry type fits any depth.
package branch_target_buffer_pkg;

   localparam int BTB_DEPTH_DEF = 6;
   localparam int TAG_MAX = 30;

   typedef struct packed {
      logic               valid;
      logic [TAG_MAX-1:0] tag;
      logic [31:0]        target;
   } btb_entry_t;

   function automatic logic [TAG_MAX-1:0] tagOf(
      input logic [31:0] pc,
      input int          depth
   );
      return TAG_MAX'(pc >> (depth + 2));
   endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: fetch and memory combinational read ports, one write port.
// Only the valid bits are reset; tag and target are written on allocation.
module btb_way
   import branch_target_buffer_pkg::*;
#(
   parameter int BTB_DEPTH = BTB_DEPTH_DEF,
   parameter int TAG_W = 32 - BTB_DEPTH - 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BTB_DEPTH-1:0] rdIdxF,
   output btb_entry_t           rdF,
   input  logic [BTB_DEPTH-1:0] rdIdxM,
   output btb_entry_t           rdM,
   input  logic                 we,
   input  logic [BTB_DEPTH-1:0] wrIdx,
   input  btb_entry_t           wrEntry
);

   localparam int SETS = 1 << BTB_DEPTH;

   logic [SETS-1:0] valid;
   logic [TAG_W-1:0] tagArr [SETS];
   logic [31:0] tgtArr [SETS];
   logic unusedTag;

   assign unusedTag = ^wrEntry.tag[TAG_MAX-1:TAG_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[wrIdx] <= wrEntry.valid;
      end
   end

   always_ff @(posedge clk) begin
      if (we && !rst) begin
         tagArr[wrIdx] <= wrEntry.tag[TAG_W-1:0];
         tgtArr[wrIdx] <= wrEntry.target;
      end
   end

   always_comb begin
      rdF.valid = valid[rdIdxF];
      rdF.tag = TAG_MAX'(tagArr[rdIdxF]);
      rdF.target = tgtArr[rdIdxF];
      rdM.valid = valid[rdIdxM];
      rdM.tag = TAG_MAX'(tagArr[rdIdxM]);
      rdM.target = tgtArr[rdIdxM];
   end

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative BTB: fetch lookup, per-set LRU, M-stage training,
// and the decode-stage pipeline register for hit and target.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int BTB_DEPTH = BTB_DEPTH_DEF,
   parameter int TAG_W = 32 - BTB_DEPTH - 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        branchM,
   input  logic [31:0] pcM,
   input  logic [31:0] targetM,
   output logic        branchF,
   output logic [31:0] targetF,
   output logic        branchD,
   output logic [31:0] targetD
);

   localparam int SETS = 1 << BTB_DEPTH;

   logic [BTB_DEPTH-1:0] setF, setM;
   logic [TAG_MAX-1:0] tagF, tagM;
   btb_entry_t e0F, e1F, e0M, e1M, wrEntry;
   logic hitF0, hitF1, hitM0, hitM1;
   logic wayF, wayM, we0, we1;
   logic [SETS-1:0] lru;
   logic unusedPc;

   assign setF = pcF[BTB_DEPTH+1:2];
   assign setM = pcM[BTB_DEPTH+1:2];
   assign tagF = tagOf(pcF, BTB_DEPTH);
   assign tagM = tagOf(pcM, BTB_DEPTH);
   assign unusedPc = ^{pcF[1:0], pcM[1:0]};

   assign wrEntry = '{valid: 1'b1, tag: tagM, target: targetM};
   assign we0 = branchM && !wayM;
   assign we1 = branchM && wayM;

   btb_way #(.BTB_DEPTH(BTB_DEPTH), .TAG_W(TAG_W)) way0 (
      .clk(clk), .rst(rst),
      .rdIdxF(setF), .rdF(e0F),
      .rdIdxM(setM), .rdM(e0M),
      .we(we0), .wrIdx(setM), .wrEntry(wrEntry)
   );

   btb_way #(.BTB_DEPTH(BTB_DEPTH), .TAG_W(TAG_W)) way1 (
      .clk(clk), .rst(rst),
      .rdIdxF(setF), .rdF(e1F),
      .rdIdxM(setM), .rdM(e1M),
      .we(we1), .wrIdx(setM), .wrEntry(wrEntry)
   );

   assign hitF0 = e0F.valid && (e0F.tag == tagF);
   assign hitF1 = e1F.valid && (e1F.tag == tagF);
   assign hitM0 = e0M.valid && (e0M.tag == tagM);
   assign hitM1 = e1M.valid && (e1M.tag == tagM);

   assign branchF = hitF0 || hitF1;
   assign wayF = !hitF0;

   always_comb begin
      targetF = '0;
      if (hitF0) begin
         targetF = e0F.target;
      end else if (hitF1) begin
         targetF = e1F.target;
      end
   end

   // Existing entry first, then a free way, then the LRU victim.
   always_comb begin
      wayM = 1'b0;
      priority case (1'b1)
         hitM0:      wayM = 1'b0;
         hitM1:      wayM = 1'b1;
         !e0M.valid: wayM = 1'b0;
         !e1M.valid: wayM = 1'b1;
         default:    wayM = lru[setM];
      endcase
   end

   // The update write comes last so it overrides a same-set lookup.
   always_ff @(posedge clk) begin
      if (rst) begin
         lru <= '0;
      end else begin
         if (branchF && !stallD) begin
            lru[setF] <= ~wayF;
         end
         if (branchM) begin
            lru[setM] <= ~wayM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flushD) begin
         branchD <= 1'b0;
         targetD <= '0;
      end else if (!stallD) begin
         branchD <= branchF;
         targetD <= targetF;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer.
// Expected values are hand-computed from the intended behaviour.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF;
   logic        stallD;
   logic        flushD;
   logic        branchM;
   logic [31:0] pcM;
   logic [31:0] targetM;
   logic        branchF;
   logic [31:0] targetF;
   logic        branchD;
   logic [31:0] targetD;

   int nTests = 0;
   int nFail = 0;

   localparam logic [31:0] PC_A = 32'h0040_0100;
   localparam logic [31:0] PC_B = 32'h0041_0100;
   localparam logic [31:0] PC_C = 32'h0042_0100;
   localparam logic [31:0] PC_N = 32'h0040_0400;
   localparam logic [31:0] T_A  = 32'h0040_0200;
   localparam logic [31:0] T_A2 = 32'h0040_0300;
   localparam logic [31:0] T_B  = 32'h0041_0200;
   localparam logic [31:0] T_C  = 32'h0042_0200;
   localparam logic [31:0] T_N  = 32'h0040_0500;

   branch_target_buffer dut (
      .clk(clk), .rst(rst),
      .pcF(pcF), .stallD(stallD), .flushD(flushD),
      .branchM(branchM), .pcM(pcM), .targetM(targetM),
      .branchF(branchF), .targetF(targetF),
      .branchD(branchD), .targetD(targetD)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
      branchM = 1'b1;
      pcM = pc;
      targetM = tgt;
      pcF = 32'h0;
      tick();
      branchM = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic hit, input logic [31:0] tgt);
      pcF = pc;
      #1;
      chk({tag, ".hit"}, 32'(branchF), 32'(hit));
      chk({tag, ".tgt"}, targetF, tgt);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      pcF = 32'h0;
      stallD = 1'b0;
      flushD = 1'b0;
      branchM = 1'b0;
      pcM = 32'h0;
      targetM = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst.branchD", 32'(branchD), 32'd0);
      chk("rst.targetD", targetD, 32'h0);

      look("cold", PC_A, 1'b0, 32'h0);
      chk("cold.branchD", 32'(branchD), 32'd0);

      // A -> way0 of set 0
      train(PC_A, T_A);
      look("trainA", PC_A, 1'b1, T_A);
      chk("trainA.branchD", 32'(branchD), 32'd1);
      chk("trainA.targetD", targetD, T_A);

      // B -> way1, then A touched so B is LRU, then C evicts B
      train(PC_B, T_B);
      look("preB", PC_B, 1'b1, T_B);
      look("touchA", PC_A, 1'b1, T_A);
      train(PC_C, T_C);
      look("evA", PC_A, 1'b1, T_A);
      look("evC", PC_C, 1'b1, T_C);
      look("evB", PC_B, 1'b0, 32'h0);

      // A MRU again so a wrong allocation would evict C
      look("preRet", PC_A, 1'b1, T_A);
      train(PC_A, T_A2);
      look("retA", PC_A, 1'b1, T_A2);
      look("retC", PC_C, 1'b1, T_C);

      pcF = PC_A;
      tick();
      chk("preStall.branchD", 32'(branchD), 32'd1);
      stallD = 1'b1;
      pcF = PC_C;
      tick();
      chk("stall1.targetD", targetD, T_A2);
      pcF = 32'h0;
      tick();
      chk("stall2.branchD", 32'(branchD), 32'd1);
      pcF = PC_B;
      tick();
      chk("stall3.targetD", targetD, T_A2);
      flushD = 1'b1;
      pcF = PC_A;
      tick();
      chk("flush.branchD", 32'(branchD), 32'd0);
      chk("flush.targetD", targetD, 32'h0);
      flushD = 1'b0;
      stallD = 1'b0;

      // update and lookup of the same PC in one cycle: no bypass
      branchM = 1'b1;
      pcM = PC_N;
      targetM = T_N;
      pcF = PC_N;
      #1;
      chk("same.hit0", 32'(branchF), 32'd0);
      tick();
      branchM = 1'b0;
      look("same.next", PC_N, 1'b1, T_N);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2.branchD", 32'(branchD), 32'd0);
      look("rst2.N", PC_N, 1'b0, 32'h0);
      look("rst2.A", PC_A, 1'b0, 32'h0);
      look("rst2.C", PC_C, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
